vppm_demod: RTL and testbench
=============================

VPPM_DEMOD -- requirements
Module: vppm_demod

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SPS, 16: ADC samples per VPPM symbol, even, 4..64.
- THR_HI, 12'd2400: slicer rising threshold.
- THR_LO, 12'd1600: slicer falling threshold; THR_LO < THR_HI.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset:
- iCLK, input, 1: the only clock. All state SHALL update on posedge iCLK.
- iRST, input, 1: asynchronous, active-low reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- iDR, input, 1: ADC data-ready level. A sample is taken only on its 0->1 transition.
- iDATA, input, 12: ADC sample, unsigned. Stable whenever iDR is high.
- iACK, input, 1: consumer acknowledges oBYTE.
- oBYTE, output, 8: decoded byte.
- oVALID, output, 1: oBYTE valid; held until acknowledged.
- oOVF, output, 1: sticky flag; a byte was lost.
- oFERR, output, 1: one-cycle pulse; framing or symbol error.
- oSLICE, output, 1: current slicer level, for debug and LED.
- oBUSY, output, 1: high whenever the state is not IDLE.

Function
REQ-004 Sample strobe:
- iDR SHALL be registered once, giving dr_q.
- stb = iDR & ~dr_q.
- stb SHALL be exactly 1 cycle wide per rising iDR edge.
- All sample-domain logic below SHALL advance only on cycles where stb=1.
REQ-005 Slicer with hysteresis, evaluated on stb:
- iDATA >= THR_HI sets slice=1.
- iDATA <= THR_LO sets slice=0.
- Otherwise slice holds.
- oSLICE=slice.
REQ-006 Slicer edge: rise = slice_new & ~slice_old, evaluated on the same stb.
REQ-007 FSM states SHALL be IDLE, START, DATA and DONE.
REQ-008 IDLE:
- scnt=0, bcnt=0, hA=0, hB=0.
- On stb with rise=1, go to START.
- That sample SHALL count as sample 0 of the start symbol, with hA=1.
REQ-009 Symbol accumulation, in START and DATA on each stb:
- Sample index scnt counts 0..SPS-1.
- scnt < SPS/2 with slice=1 increments hA.
- scnt >= SPS/2 with slice=1 increments hB.
- hA and hB SHALL be ceil(log2(SPS/2+1)) bits wide and SHALL NOT wrap.
REQ-010 Symbol decision, on the stb where scnt=SPS-1 (after including that sample):
- hA > hB decodes bit 0.
- hB > hA decodes bit 1.
- hA == hB is a symbol error.
- After the decision, scnt, hA and hB SHALL clear.
REQ-011 START decision:
- Bit 0: go to DATA with bcnt=0.
- Bit 1 or symbol error: pulse oFERR and go to IDLE.
REQ-012 DATA decision:
- Bit 1 or 0: shift into the shift register LSB first (bit bcnt) and increment bcnt.
- After bcnt reaches 8, go to DONE.
- Symbol error: pulse oFERR, discard the partial byte, go to IDLE.
REQ-013 DONE: exactly 1 cycle, with no stb dependency.
- oVALID=0: load oBYTE, set oVALID=1.
- oVALID=1 and iACK=0: leave oBYTE unchanged and set oOVF=1.
- Either way, go to IDLE.
REQ-014 Handshake:
- On posedge iCLK with oVALID=1 and iACK=1, clear oVALID.
- iACK while oVALID=0 SHALL be ignored.
- If DONE coincides with iACK and oVALID=1, the new byte SHALL load and oVALID SHALL stay 1 with no overflow.
REQ-015 Latency: oVALID SHALL rise 2 iCLK cycles after the stb carrying the last sample of data bit 7.
REQ-016 oFERR SHALL be exactly 1 cycle wide per error event.
REQ-017 A rise during START or DATA SHALL NOT resynchronise symbol timing.
REQ-018 oBUSY = (state != IDLE).

Reset
REQ-019 With iRST=0, the following SHALL clear immediately and asynchronously:
- state=IDLE.
- dr_q, slice, scnt, bcnt, hA, hB and the shift register = 0.
- oBYTE=8'h00, oVALID=0, oOVF=0, oFERR=0, oSLICE=0, oBUSY=0.
REQ-020 Reset mid-frame SHALL discard the partial byte, emit no oFERR, and need no stb to take effect.
REQ-021 oOVF SHALL clear only on reset.

Verification
REQ-022 SPS=16, send 0xA5 (start symbol then 8 symbols, high 4000 / low 0), iACK tied 0: oVALID=1, oBYTE=8'hA5, oFERR never pulses.
REQ-023 Hold iDR=1 for 50 cycles with iDATA=4000: exactly one stb and one slicer update; no further state change.
REQ-024 Hysteresis: samples 2500, 2000, 1700, 1500, 2000 -> oSLICE 1, 1, 1, 0, 0.
REQ-025 Symbol with hA==hB=4 in data bit 3: one oFERR pulse, state returns to IDLE, oVALID unchanged.
REQ-026 Two frames 0x3C then 0x81 with no iACK: oBYTE=8'h3C, oOVF=1; then iACK for 1 cycle -> oVALID=0, oOVF stays 1.
REQ-027 iRST asserted at data bit 4: outputs zero within the same cycle; a following clean frame 0x0F decodes to oBYTE=8'h0F.

Source files
------------

// File: rtl/vppm_demod.sv
// rtl/vppm_demod.sv - VPPM demodulator: sample strobe, hysteresis slicer, symbol integrator, byte framer
module vppm_demod #(
    parameter int          SPS    = 16,
    parameter logic [11:0] THR_HI = 12'd2400,
    parameter logic [11:0] THR_LO = 12'd1600
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDR,
    input  logic [11:0] iDATA,
    input  logic        iACK,
    output logic [7:0]  oBYTE,
    output logic        oVALID,
    output logic        oOVF,
    output logic        oFERR,
    output logic        oSLICE,
    output logic        oBUSY
);

    localparam int HALF = SPS / 2;
    localparam int SW   = $clog2(SPS);
    localparam int HW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          dr_q, dr_d;
    logic          slice_q, slice_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [HW-1:0] ha_q, ha_d;
    logic [HW-1:0] hb_q, hb_d;
    logic [7:0]    sreg_q, sreg_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;

    logic          stb;
    logic          slice_new;
    logic          rise;
    logic [HW-1:0] ha_n, hb_n;
    logic          sym_err;
    logic          sym_bit;
    logic          last_smp;

    assign stb = iDR & ~dr_q;

    always_comb begin
        slice_new = slice_q;
        if (stb) begin
            if (iDATA >= THR_HI) begin
                slice_new = 1'b1;
            end else if (iDATA <= THR_LO) begin
                slice_new = 1'b0;
            end
        end
    end

    assign rise = stb & slice_new & ~slice_q;

    // Half-symbol integrators saturate at HALF so a noisy slicer cannot wrap them.
    always_comb begin
        ha_n = ha_q;
        hb_n = hb_q;
        if (slice_new) begin
            if (scnt_q < SW'(HALF)) begin
                if (ha_q != HW'(HALF)) begin
                    ha_n = ha_q + HW'(1);
                end
            end else begin
                if (hb_q != HW'(HALF)) begin
                    hb_n = hb_q + HW'(1);
                end
            end
        end
    end

    assign sym_err  = (ha_n == hb_n);
    assign sym_bit  = (hb_n > ha_n);
    assign last_smp = (scnt_q == SW'(SPS - 1));

    always_comb begin
        state_d = state_q;
        dr_d    = iDR;
        slice_d = slice_new;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        ha_d    = ha_q;
        hb_d    = hb_q;
        sreg_d  = sreg_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ferr_d  = 1'b0;

        if (valid_q && iACK) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                scnt_d = '0;
                bcnt_d = '0;
                ha_d   = '0;
                hb_d   = '0;
                if (rise) begin
                    state_d = S_START;
                    scnt_d  = SW'(1);
                    ha_d    = HW'(1);
                end
            end

            S_START, S_DATA: begin
                if (stb) begin
                    if (last_smp) begin
                        scnt_d = '0;
                        ha_d   = '0;
                        hb_d   = '0;
                        if (state_q == S_START) begin
                            if (!sym_err && !sym_bit) begin
                                state_d = S_DATA;
                                bcnt_d  = '0;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else if (sym_err) begin
                            ferr_d  = 1'b1;
                            state_d = S_IDLE;
                            sreg_d  = '0;
                            bcnt_d  = '0;
                        end else begin
                            sreg_d[bcnt_q[2:0]] = sym_bit;
                            bcnt_d              = bcnt_q + 4'd1;
                            if (bcnt_q == 4'd7) begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                        ha_d   = ha_n;
                        hb_d   = hb_n;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                sreg_d  = '0;
                bcnt_d  = '0;
                // A simultaneous acknowledge frees the holding register, so no byte is lost.
                if (!valid_q || iACK) begin
                    byte_d  = sreg_q;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            dr_q    <= 1'b0;
            slice_q <= 1'b0;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            ha_q    <= '0;
            hb_q    <= '0;
            sreg_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            slice_q <= slice_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
            sreg_q  <= sreg_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    assign oBYTE  = byte_q;
    assign oVALID = valid_q;
    assign oOVF   = ovf_q;
    assign oFERR  = ferr_q;
    assign oSLICE = slice_q;
    assign oBUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_vppm_demod.sv
// tb/tb_vppm_demod.sv - scoreboard bench for vppm_demod
module tb_vppm_demod;

    localparam int SPS  = 16;
    localparam int HALF = SPS / 2;

    logic        clk;
    logic        rst_n;
    logic        dr;
    logic [11:0] data;
    logic        ack;
    logic [7:0]  obyte;
    logic        ovalid;
    logic        oovf;
    logic        oferr;
    logic        oslice;
    logic        obusy;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  exp_q[$];
    logic        vld_prev;
    logic        ferr_prev;
    int          ferr_cnt;
    int          ferr_hi;

    vppm_demod #(
        .SPS   (SPS),
        .THR_HI(12'd2400),
        .THR_LO(12'd1600)
    ) u_dut (
        .iCLK  (clk),
        .iRST  (rst_n),
        .iDR   (dr),
        .iDATA (data),
        .iACK  (ack),
        .oBYTE (obyte),
        .oVALID(ovalid),
        .oOVF  (oovf),
        .oFERR (oferr),
        .oSLICE(oslice),
        .oBUSY (obusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ovalid && !vld_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_byte", {24'd0, obyte}, {24'd0, exp_q.pop_front()});
            end
        end
        if (oferr) ferr_hi++;
        if (oferr && !ferr_prev) ferr_cnt++;
        vld_prev  <= ovalid;
        ferr_prev <= oferr;
    end

    task automatic sample(input logic [11:0] v);
        @(posedge clk);
        #1;
        dr   = 1'b1;
        data = v;
        @(posedge clk);
        #1;
        dr = 1'b0;
    endtask

    task automatic sym_pat(input logic [SPS-1:0] pat);
        for (int i = 0; i < SPS; i++) begin
            sample(pat[i] ? 12'd4000 : 12'd0);
        end
    endtask

    task automatic symbol(input logic b);
        logic [SPS-1:0] pat;
        for (int i = 0; i < SPS; i++) begin
            pat[i] = (i < HALF) ^ b;
        end
        sym_pat(pat);
    endtask

    task automatic gap();
        sample(12'd0);
        sample(12'd0);
    endtask

    task automatic frame(input logic [7:0] b, input logic expect_new);
        gap();
        if (expect_new) exp_q.push_back(b);
        symbol(1'b0);
        for (int i = 0; i < 8; i++) begin
            symbol(b[i]);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SPS-1:0] pat;
        int             ferr_base;
        n_cmp = 0;
        n_bad = 0;
        ferr_cnt = 0;
        ferr_hi = 0;
        vld_prev = 1'b0;
        ferr_prev = 1'b0;
        rst_n = 1'b0;
        dr = 1'b0;
        data = 12'd0;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte", {24'd0, obyte}, 32'h00);
        chk("rst_valid", {31'd0, ovalid}, 32'd0);
        chk("rst_ovf", {31'd0, oovf}, 32'd0);
        chk("rst_ferr", {31'd0, oferr}, 32'd0);
        chk("rst_slice", {31'd0, oslice}, 32'd0);
        chk("rst_busy", {31'd0, obusy}, 32'd0);
        rst_n = 1'b1;

        // Hysteresis sequence
        sample(12'd2500); chk("hys0", {31'd0, oslice}, 32'd1);
        sample(12'd2000); chk("hys1", {31'd0, oslice}, 32'd1);
        sample(12'd1700); chk("hys2", {31'd0, oslice}, 32'd1);
        sample(12'd1500); chk("hys3", {31'd0, oslice}, 32'd0);
        sample(12'd2000); chk("hys4", {31'd0, oslice}, 32'd0);
        chk("hys_busy", {31'd0, obusy}, 32'd1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        chk("hys_rst_busy", {31'd0, obusy}, 32'd0);

        // Basic frame, no ack
        frame(8'hA5, 1'b1);
        chk("a5_valid", {31'd0, ovalid}, 32'd1);
        chk("a5_byte", {24'd0, obyte}, 32'hA5);
        chk("a5_busy", {31'd0, obusy}, 32'd0);
        chk("a5_ferr", ferr_cnt, 0);
        do_ack();
        chk("a5_ack_valid", {31'd0, ovalid}, 32'd0);

        // Long iDR high: one strobe only, then finish the frame
        gap();
        @(posedge clk); #1;
        dr = 1'b1;
        data = 12'd4000;
        repeat (50) @(posedge clk);
        #1;
        dr = 1'b0;
        chk("hold_busy", {31'd0, obusy}, 32'd1);
        chk("hold_slice", {31'd0, oslice}, 32'd1);
        exp_q.push_back(8'h5A);
        for (int i = 1; i < SPS; i++) sample(i < HALF ? 12'd4000 : 12'd0);
        for (int i = 0; i < 8; i++) symbol(8'h5A >> i);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_byte", {24'd0, obyte}, 32'h5A);
        chk("hold_valid", {31'd0, ovalid}, 32'd1);
        do_ack();

        // Bad start symbol (all high)
        gap();
        sym_pat({SPS{1'b1}});
        gap();
        chk("start_err_cnt", ferr_cnt, 1);
        chk("start_err_busy", {31'd0, obusy}, 32'd0);

        // Symbol error in data bit 3 while a byte is pending
        frame(8'h11, 1'b1);
        gap();
        symbol(1'b0);
        for (int i = 0; i < 3; i++) symbol(1'b1);
        for (int i = 0; i < SPS; i++) pat[i] = (i % HALF) < 4;
        sym_pat(pat);
        repeat (3) @(posedge clk);
        #1;
        chk("sym_err_cnt", ferr_cnt, 2);
        chk("sym_err_busy", {31'd0, obusy}, 32'd0);
        chk("sym_err_valid", {31'd0, ovalid}, 32'd1);
        chk("sym_err_byte", {24'd0, obyte}, 32'h11);
        chk("sym_err_ovf", {31'd0, oovf}, 32'd0);
        do_ack();

        // Overflow: second frame lost
        frame(8'h3C, 1'b1);
        frame(8'h81, 1'b0);
        chk("ovf_byte", {24'd0, obyte}, 32'h3C);
        chk("ovf_flag", {31'd0, oovf}, 32'd1);
        do_ack();
        chk("ovf_ack_valid", {31'd0, ovalid}, 32'd0);
        chk("ovf_sticky", {31'd0, oovf}, 32'd1);

        // Reset in the middle of data bit 4
        ferr_base = ferr_cnt;
        gap();
        symbol(1'b0);
        for (int i = 0; i < 4; i++) symbol(1'b0);
        for (int i = 0; i < 3; i++) sample(12'd4000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_slice", {31'd0, oslice}, 32'd0);
        chk("mid_rst_busy", {31'd0, obusy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, oovf}, 32'd0);
        chk("mid_rst_byte", {24'd0, obyte}, 32'h00);
        chk("mid_rst_valid", {31'd0, ovalid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(8'h0F, 1'b1);
        chk("post_rst_byte", {24'd0, obyte}, 32'h0F);
        chk("post_rst_valid", {31'd0, ovalid}, 32'd1);
        chk("post_rst_ovf", {31'd0, oovf}, 32'd0);
        chk("post_rst_ferr", ferr_cnt, ferr_base);

        chk("ferr_width", ferr_hi, ferr_cnt);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
